// File: rtl/shift_loader_pkg.sv
// Shared types and helpers for the shift_loader parallel-in/serial-out stage.
// The optional parity beat is enabled with the SHIFT_LOADER_PARITY_EN macro.
package shift_loader_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bits needed to hold a down-counter whose largest value is max_count.
  function automatic int cnt_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/shift_loader_if.sv
// Handshake bundle for shift_loader: parallel word in, serial bit stream out.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// the sender holds data stable while valid=1 and ready=0.
interface shift_loader_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             sout_ready;
  logic             sout_last;
  logic             busy;

  modport master (
    output din, din_valid, sout_ready,
    input  din_ready, sout, sout_valid, sout_last, busy
  );

  modport slave (
    input  din, din_valid, sout_ready,
    output din_ready, sout, sout_valid, sout_last, busy
  );
endinterface

// File: rtl/shift_loader_cell.sv
// One shift-register bit: 2:1 load/shift select feeding an async-reset D flip-flop.
module shift_bit_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  input  logic d_load,
  input  logic d_shift,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= load ? d_load : d_shift;
    end
  end

endmodule

// File: rtl/shift_loader.sv
// Parallel-in, serial-out shifter with zero-bubble reload between words.
// Define SHIFT_LOADER_PARITY_EN to append an even-parity beat after each word.
module shift_loader
  import shift_loader_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  shift_loader_if.slave bus,
  output state_t        state_dbg
);

`ifdef SHIFT_LOADER_PARITY_EN
  localparam int MAX_CNT = WIDTH;
`else
  localparam int MAX_CNT = WIDTH - 1;
`endif
  localparam int            CW       = cnt_width(MAX_CNT);
  localparam logic [CW-1:0] LOAD_CNT = CW'(MAX_CNT);

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_in;
  logic             cnt_zero;
  logic             din_rdy;
  logic             load_word;
  logic             shift_en;
  logic             cell_en;
  logic             data_bit;
  logic             sout_bit;

  assign cnt_zero = (cnt == '0);
  assign din_rdy  = (state == IDLE) || ((state == SHIFT) && cnt_zero && bus.sout_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    load_word = 1'b0;
    shift_en  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.din_valid) begin
          load_word = 1'b1;
          cnt_n     = LOAD_CNT;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.sout_ready) begin
          if (!cnt_zero) begin
            shift_en = 1'b1;
            cnt_n    = cnt - 1'b1;
          end else if (bus.din_valid) begin
            // Final beat consumed and a new word is waiting: reload without a bubble.
            load_word = 1'b1;
            cnt_n     = LOAD_CNT;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Neighbour bit seen by each cell when shifting; the vacated end fills with 0.
  generate
    if (MSB_FIRST) begin : g_shift_left
      assign shift_in = {shreg[WIDTH-2:0], 1'b0};
      assign data_bit = shreg[WIDTH-1];
    end else begin : g_shift_right
      assign shift_in = {1'b0, shreg[WIDTH-1:1]};
      assign data_bit = shreg[0];
    end
  endgenerate

  assign cell_en = load_word | shift_en;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      shift_bit_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .en      (cell_en),
        .load    (load_word),
        .d_load  (bus.din[i]),
        .d_shift (shift_in[i]),
        .q       (shreg[i])
      );
    end
  endgenerate

`ifdef SHIFT_LOADER_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (load_word) begin
      parity_q <= ^bus.din;
    end
  end

  // Count 0 is the parity beat; data bits occupy counts WIDTH down to 1.
  assign sout_bit = cnt_zero ? parity_q : data_bit;
`else
  assign sout_bit = data_bit;
`endif

  assign bus.din_ready  = din_rdy;
  assign bus.sout       = (state == SHIFT) && sout_bit;
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout_last  = (state == SHIFT) && cnt_zero;
  assign bus.busy       = (state == SHIFT);
  assign state_dbg      = state;

endmodule

// File: tb/tb_shift_loader.sv
// Self-checking bench for shift_loader: one MSB-first and one LSB-first instance
// share stimulus; a bit-queue model and directed vector tables supply expectations.
module tb_shift_loader;
  import shift_loader_pkg::*;

  localparam int W = 8;
`ifdef SHIFT_LOADER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] din;
  logic         din_valid;
  logic         sout_ready;
  state_t       st_m, st_l;

  shift_loader_if #(.WIDTH(W)) if_m ();
  shift_loader_if #(.WIDTH(W)) if_l ();

  assign if_m.din = din;
  assign if_m.din_valid = din_valid;
  assign if_m.sout_ready = sout_ready;
  assign if_l.din = din;
  assign if_l.din_valid = din_valid;
  assign if_l.sout_ready = sout_ready;

  shift_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(if_m), .state_dbg(st_m)
  );
  shift_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(if_l), .state_dbg(st_l)
  );

  // ---------------- scoreboard ----------------
  logic exp_m_q[$];
  logic exp_l_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  logic last_acc;

  logic [63:0] stream_m, stream_l;
  int beat_n, last_n, last_idx, valid_n, first_cyc, last_cyc, cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic e_valid, e_m, e_l, e_last, e_rdy;
    e_valid = (exp_m_q.size() > 0);
    e_m     = e_valid ? exp_m_q[0] : 1'b0;
    e_l     = e_valid ? exp_l_q[0] : 1'b0;
    e_last  = (exp_m_q.size() == 1);
    e_rdy   = (exp_m_q.size() == 0) || ((exp_m_q.size() == 1) && sout_ready);
    chk("m_sout_valid", 64'(if_m.sout_valid), 64'(e_valid));
    chk("m_sout",       64'(if_m.sout),       64'(e_m));
    chk("m_sout_last",  64'(if_m.sout_last),  64'(e_last));
    chk("m_busy",       64'(if_m.busy),       64'(e_valid));
    chk("m_din_ready",  64'(if_m.din_ready),  64'(e_rdy));
    chk("m_state",      64'(st_m),            64'(e_valid));
    chk("l_sout_valid", 64'(if_l.sout_valid), 64'(e_valid));
    chk("l_sout",       64'(if_l.sout),       64'(e_l));
    chk("l_sout_last",  64'(if_l.sout_last),  64'(e_last));
    chk("l_din_ready",  64'(if_l.din_ready),  64'(e_rdy));
  endtask

  function automatic void push_word(input logic [W-1:0] w);
    for (int k = W - 1; k >= 0; k--) exp_m_q.push_back(w[k]);
    for (int k = 0; k < W; k++) exp_l_q.push_back(w[k]);
`ifdef SHIFT_LOADER_PARITY_EN
    exp_m_q.push_back(^w);
    exp_l_q.push_back(^w);
`endif
  endfunction

  function automatic void model_update();
    logic acc;
    last_acc = 1'b0;
    if (rst) begin
      exp_m_q.delete();
      exp_l_q.delete();
      return;
    end
    acc = din_valid && ((exp_m_q.size() == 0) || ((exp_m_q.size() == 1) && sout_ready));
    if (sout_ready && exp_m_q.size() > 0) begin
      void'(exp_m_q.pop_front());
      void'(exp_l_q.pop_front());
    end
    if (acc) push_word(din);
    last_acc = acc;
  endfunction

  task automatic clear_capture();
    stream_m = '0; stream_l = '0;
    beat_n = 0; last_n = 0; last_idx = -1;
    valid_n = 0; first_cyc = -1; last_cyc = -1;
  endtask

  // One clock: check and capture at negedge, advance model at posedge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    if (if_m.sout_valid) begin
      valid_n++;
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
      if (sout_ready) begin
        stream_m = {stream_m[62:0], if_m.sout};
        stream_l = {stream_l[62:0], if_l.sout};
        if (if_m.sout_last) begin
          last_n++;
          last_idx = beat_n;
        end
        beat_n++;
      end
    end
    cyc++;
    @(posedge clk);
    model_update();
    #1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] din;
    logic [7:0]   pat;    // sout_ready pattern, bit 0 first, repeating
    logic [W-1:0] exp_m;  // serial stream, first bit in the MSB
    logic [W-1:0] exp_l;
    logic         exp_par;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v, input int idx);
    int guard;
    logic [W-1:0] got_m, got_l;
    clear_capture();
    din = v.din; din_valid = 1'b1; sout_ready = 1'b1;
    cycle();
    din_valid = 1'b0;
    din = W'($urandom);
    guard = 0;
    while (beat_n < NB && guard < 200) begin
      sout_ready = v.pat[guard % 8];
      cycle();
      guard++;
    end
    chk($sformatf("v%0d_timeout", idx), 64'(guard < 200), 64'(1));
`ifdef SHIFT_LOADER_PARITY_EN
    got_m = stream_m[NB-1:1];
    got_l = stream_l[NB-1:1];
    chk($sformatf("v%0d_par_m", idx), 64'(stream_m[0]), 64'(v.exp_par));
    chk($sformatf("v%0d_par_l", idx), 64'(stream_l[0]), 64'(v.exp_par));
`else
    got_m = stream_m[W-1:0];
    got_l = stream_l[W-1:0];
`endif
    chk($sformatf("v%0d_stream_m", idx), 64'(got_m), 64'(v.exp_m));
    chk($sformatf("v%0d_stream_l", idx), 64'(got_l), 64'(v.exp_l));
    chk($sformatf("v%0d_last_count", idx), 64'(last_n), 64'(1));
    chk($sformatf("v%0d_last_pos", idx), 64'(last_idx), 64'(NB - 1));
    sout_ready = 1'b1;
    repeat (2) cycle();
  endtask

  initial begin
    int acc_n, guard;
    logic [63:0] b2b_exp;

    rst = 1'b1; din = '0; din_valid = 1'b0; sout_ready = 1'b0; cyc = 0;
    clear_capture();
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) cycle();

    vecs[0] = '{din: 8'hA5, pat: 8'hFF, exp_m: 8'hA5, exp_l: 8'hA5, exp_par: 1'b0};
    vecs[1] = '{din: 8'h01, pat: 8'hFF, exp_m: 8'h01, exp_l: 8'h80, exp_par: 1'b1};
    vecs[2] = '{din: 8'hC3, pat: 8'h99, exp_m: 8'hC3, exp_l: 8'hC3, exp_par: 1'b0};
    vecs[3] = '{din: 8'h07, pat: 8'hFF, exp_m: 8'h07, exp_l: 8'hE0, exp_par: 1'b1};
    vecs[4] = '{din: 8'h1E, pat: 8'h35, exp_m: 8'h1E, exp_l: 8'h78, exp_par: 1'b0};
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset in the middle of a word.
    din = 8'hA5; din_valid = 1'b1; sout_ready = 1'b1;
    cycle();
    din_valid = 1'b0;
    repeat (3) cycle();
    rst = 1'b1;
    #1;
    exp_m_q.delete();
    exp_l_q.delete();
    chk("rst_async_valid", 64'(if_m.sout_valid), 64'(0));
    check_outputs();
    repeat (2) cycle();
    rst = 1'b0;
    clear_capture();
    repeat (10) cycle();
    chk("rst_no_beats", 64'(valid_n), 64'(0));

    // Back-to-back words with din_valid held high.
    clear_capture();
    din = 8'hFF; din_valid = 1'b1; sout_ready = 1'b1;
    acc_n = 0; guard = 0;
    while (!(acc_n == 2 && exp_m_q.size() == 0) && guard < 80) begin
      cycle();
      if (last_acc) begin
        acc_n++;
        if (acc_n == 1) din = 8'h00;
        if (acc_n == 2) din_valid = 1'b0;
      end
      guard++;
    end
    cycle();
`ifdef SHIFT_LOADER_PARITY_EN
    b2b_exp = 64'({8'hFF, 1'b0, 8'h00, 1'b0});
`else
    b2b_exp = 64'(16'hFF00);
`endif
    chk("b2b_timeout", 64'(guard < 80), 64'(1));
    chk("b2b_stream_m", stream_m & ((64'd1 << (2 * NB)) - 1), b2b_exp);
    chk("b2b_valid_beats", 64'(valid_n), 64'(2 * NB));
    chk("b2b_contiguous", 64'(last_cyc - first_cyc + 1), 64'(2 * NB));
    chk("b2b_last_count", 64'(last_n), 64'(2));

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      din        = W'($urandom_range(0, 255));
      din_valid  = ($urandom_range(0, 9) < 5);
      sout_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    din_valid = 1'b0; sout_ready = 1'b1;
    repeat (NB + 2) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
